ps2_frame_rx: RTL and testbench
===============================

Name: ps2_frame_rx

Overview:
- PS/2 device-to-host receive front end.
- Synchronizes and glitch-filters the raw PS2_CLK/PS2_DAT lines and assembles 11-bit frames.
- Checks the start, odd-parity and stop bits, and emits validated scan-code bytes.
- Folds E0 (extended) and F0 (break) prefixes into single key events, which feed the scan-code classification and HEX display stages downstream.

Parameters:
- FILTER_LEN, 8: consecutive identical CLOCK_50 samples of the synchronized PS2_CLK needed before the filtered clock changes level.
- TIMEOUT_CYCLES, 100000: CLOCK_50 cycles (2 ms at 50 MHz) allowed between sample strobes inside a frame before the frame is aborted.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- Reset  input  1  asynchronous, active-high reset.
- PS2_CLK  input  1  raw PS/2 clock line (receive only; block never drives it).
- PS2_DAT  input  1  raw PS/2 data line (receive only).
- byte_out  output  8  last validated frame data byte.
- byte_valid  output  1  one-cycle pulse; byte_out is valid in that cycle.
- key_code  output  8  scan code of the last key event.
- key_ext  output  1  key event was E0-prefixed.
- key_break  output  1  key event was F0-prefixed (release).
- key_valid  output  1  one-cycle pulse; key_code, key_ext and key_break are valid in that cycle.
- parity_err  output  1  one-cycle pulse on a parity failure.
- frame_err  output  1  one-cycle pulse on a bad start bit, bad stop bit or timeout.

Behaviour:
- Interface: one clock (CLOCK_50); reset (Reset) is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - Synchronizer flops and filtered clock are 1 (bus idle high), so no edge is seen on release.
  - FSM in IDLE; bit counter, timeout counter and prefix flags cleared.
- Input path:
  - 2-flop synchronizer on each line.
  - Filter counter: the filtered clock takes the synchronized clock's value after FILTER_LEN consecutive equal samples. Shorter pulses are ignored.
  - Sample strobe: 1 on a filtered-clock 1->0 transition. Data is taken from synchronized PS2_DAT in the strobe cycle.
- FSM states: IDLE, RECV, CHECK.
  - IDLE: a strobe with data 0 (start bit) -> RECV, bit count 0. A strobe with data 1 -> frame_err pulse, remain IDLE.
  - RECV: each strobe shifts data in, LSB first: 8 data bits, then parity, then stop. After the stop-bit strobe -> CHECK.
  - RECV timeout: timeout counter clears on every strobe. If it reaches TIMEOUT_CYCLES -> frame_err pulse, discard partial frame, clear prefix flags, go to IDLE.
  - CHECK (one cycle):
    - Parity is odd: XOR of the 8 data bits and the parity bit must equal 1. On failure -> parity_err pulse.
    - Else if stop bit != 1 -> frame_err pulse.
    - Else -> byte_out = data and byte_valid pulse.
    - Always returns to IDLE. Errors clear the prefix flags.
  - Latency: byte_valid asserts exactly 1 cycle after the stop-bit strobe cycle.
- Event assembly on byte_valid, registered, so key_valid asserts 1 cycle after byte_valid:
  - E0: set ext flag, no event.
  - F0: set break flag, no event.
  - AA, FA, EE, FE, 00, FF: no event; clear both flags.
  - E1: no event; flags unchanged.
  - Any other byte: key_code = byte, key_ext = ext flag, key_break = break flag, key_valid pulse; clear both flags.
  - key_code, key_ext and key_break hold their values until the next event.
- Boundaries:
  - Repeated E0 or F0 simply keeps its flag set.
  - F0 followed by E0 gives ext = 1 and break = 1 (order-independent).
  - A strobe arriving during CHECK cannot occur, because a strobe needs ≥ FILTER_LEN+1 cycles between edges.
  - Reset asserted mid-frame aborts immediately with no output pulse.
  - Simultaneous timeout and strobe: the strobe wins and the counter clears.

Test Plan:
- Clean frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) at ~12 kHz PS/2 clock -> byte_out=1C with a single byte_valid pulse 1 cycle after the stop strobe; next cycle key_valid with key_code=1C, key_ext=0, key_break=0.
- Frames F0, 1C -> byte_valid twice. key_valid only once, with key_code=1C and key_break=1.
- Frames E0, F0, 75 -> three byte_valid pulses and one key_valid with key_code=75, key_ext=1, key_break=1. A following frame 75 gives key_ext=0, key_break=0 (flags cleared).
- Parity error (0x1C sent with parity bit 1) after frame E0 -> parity_err pulse, no byte_valid. Next frame 32 gives key_valid with key_ext=0.
- Timeout: start bit plus 4 data bits, then the clock is held high for TIMEOUT_CYCLES -> frame_err pulse, FSM back to IDLE. A subsequent clean 0x32 frame decodes correctly.
- Glitch and reset:
  - A 3-cycle low glitch on PS2_CLK (FILTER_LEN=8) mid-frame -> no extra bit; the frame still decodes correctly.
  - Reset asserted after bit 5 -> all outputs 0, no pulses; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// PS/2 device-to-host receive front end. The raw PS/2 clock and data lines
// are synchronized and the clock is glitch-filtered. 11-bit frames are
// assembled and their start, odd-parity and stop bits are checked. Good
// bytes are then folded with their E0 (extended) and F0 (break) prefixes
// into single key events.
//
// Ports:
//   CLOCK_50   in   system clock (50 MHz)
//   Reset      in   asynchronous, active-high reset
//   PS2_CLK    in   raw PS/2 clock line (never driven by this block)
//   PS2_DAT    in   raw PS/2 data line (never driven by this block)
//   byte_out   out  [7:0] last validated frame data byte
//   byte_valid out  one-cycle pulse, byte_out valid
//   key_code   out  [7:0] scan code of the last key event (held)
//   key_ext    out  last key event was E0-prefixed (held)
//   key_break  out  last key event was F0-prefixed (held)
//   key_valid  out  one-cycle pulse, key_* valid
//   parity_err out  one-cycle pulse on a parity failure
//   frame_err  out  one-cycle pulse on bad start, bad stop or timeout
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t        state;
    logic          clk_meta, clk_sync, dat_meta, dat_sync;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          strobe;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift_reg;
    logic [TW-1:0] timeout_cnt;
    logic          flag_clr;
    logic          ext_flag, break_flag;

    // Two-flop synchronizers. They reset to 1 because the idle bus is high,
    // so releasing reset never looks like a falling clock edge.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    // The counter runs only while the synchronized clock disagrees with the
    // filtered level. Any agreeing sample restarts it, so a pulse shorter than
    // FILTER_LEN samples never reaches the filtered clock.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign strobe = clk_filt_d & ~clk_filt;

    // Frame FSM. The shift register is 9 bits wide: 8 data bits plus parity.
    // The stop bit is taken directly from the line on the last strobe. All
    // checks are resolved on that strobe, so the registered result pulses
    // are visible during the single CHECK cycle, one cycle after the strobe.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            timeout_cnt <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            flag_clr    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            flag_clr   <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt     <= '0;
                    timeout_cnt <= '0;
                    if (strobe) begin
                        if (!dat_sync) state <= RECV;
                        else           frame_err <= 1'b1;
                    end
                end
                RECV: begin
                    // A strobe takes priority over an expiring timeout.
                    if (strobe) begin
                        timeout_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            state <= CHECK;
                            if (^shift_reg != 1'b1) begin
                                parity_err <= 1'b1;
                                flag_clr   <= 1'b1;
                            end else if (!dat_sync) begin
                                frame_err <= 1'b1;
                                flag_clr  <= 1'b1;
                            end else begin
                                byte_out   <= shift_reg[7:0];
                                byte_valid <= 1'b1;
                            end
                        end else begin
                            shift_reg <= {dat_sync, shift_reg[8:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        flag_clr  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                CHECK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Prefix folding. E0 and F0 only set flags. Protocol replies (AA, FA,
    // EE, FE, 00, FF) and frame errors drop any pending prefix. E1 (pause
    // sequence) leaves the flags alone. Every other byte becomes a key event.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_valid  <= 1'b0;
            ext_flag   <= 1'b0;
            break_flag <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (flag_clr) begin
                ext_flag   <= 1'b0;
                break_flag <= 1'b0;
            end else if (byte_valid) begin
                case (byte_out)
                    8'hE0: ext_flag   <= 1'b1;
                    8'hF0: break_flag <= 1'b1;
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                        ext_flag   <= 1'b0;
                        break_flag <= 1'b0;
                    end
                    8'hE1: begin
                    end
                    default: begin
                        key_code   <= byte_out;
                        key_ext    <= ext_flag;
                        key_break  <= break_flag;
                        key_valid  <= 1'b1;
                        ext_flag   <= 1'b0;
                        break_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx
// Self-checking bench for ps2_frame_rx. A directed table of frames
// exercises prefix folding, parity and stop errors and a clock glitch.
// Hand-written sequences cover the timeout and mid-frame reset cases.
// Randomized frames are then checked against a small key-event model.
module tb_ps2_frame_rx;

    localparam int FILTER = 8;
    localparam int TMO    = 400;
    localparam int HALF   = 30;
    localparam int SETTLE = 40;

    logic       clock = 1'b0;
    logic       Reset;
    logic       PS2_CLK, PS2_DAT;
    logic [7:0] byte_out, key_code;
    logic       byte_valid, key_ext, key_break, key_valid, parity_err, frame_err;

    int testsRun  = 0;
    int failCount = 0;
    int cyc = 0;
    int lastFall;
    int bvCount = 0, kvCount = 0, peCount = 0, feCount = 0;
    int bvCyc = 0, kvCyc = 0;
    logic [7:0] bvByte, kvCode;
    logic       kvExt, kvBrk;
    int b0, k0, p0, f0;

    ps2_frame_rx #(.FILTER_LEN(FILTER), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50  (clock),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .key_valid (key_valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampling on the inactive edge.
    always @(negedge clock) begin
        if (byte_valid) begin bvCount++; bvByte = byte_out; bvCyc = cyc; end
        if (key_valid) begin
            kvCount++; kvCode = key_code; kvExt = key_ext; kvBrk = key_break; kvCyc = cyc;
        end
        if (parity_err) peCount++;
        if (frame_err)  feCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives the first nbits of an 11-bit frame (bit 0 = start). Data changes
    // while the clock is high. glitchAt inserts a 3-cycle low pulse on the
    // clock during that bit's high phase.
    task automatic applyStimulus(input logic [10:0] bits, input int nbits, input int glitchAt);
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = bits[i];
            if (i == glitchAt) begin
                repeat (10) @(negedge clock);
                PS2_CLK = 1'b0;
                repeat (3) @(negedge clock);
                PS2_CLK = 1'b1;
                repeat (HALF - 13) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            PS2_CLK  = 1'b0;
            lastFall = cyc;
            repeat (HALF) @(negedge clock);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
    endtask

    function automatic logic [10:0] mkFrame(input logic [7:0] d, input bit badPar, input bit badStop);
        logic par;
        par = (~^d) ^ badPar;
        return {~badStop, par, d, 1'b0};
    endfunction

    task automatic snap();
        b0 = bvCount; k0 = kvCount; p0 = peCount; f0 = feCount;
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit badPar, input bit badStop, input int glitchAt);
        snap();
        applyStimulus(mkFrame(d, badPar, badStop), 11, glitchAt);
        repeat (SETTLE) @(negedge clock);
    endtask

    task automatic checkFrame(input string tag, input int expBv, input logic [7:0] expByte,
                              input int expKv, input logic [7:0] expCode, input bit expExt,
                              input bit expBrk, input int expPe, input int expFe);
        checkOutput({tag, " byte_valid count"}, bvCount - b0, expBv);
        checkOutput({tag, " key_valid count"}, kvCount - k0, expKv);
        checkOutput({tag, " parity_err count"}, peCount - p0, expPe);
        checkOutput({tag, " frame_err count"}, feCount - f0, expFe);
        if (expBv == 1) begin
            checkOutput({tag, " byte_out"}, bvByte, expByte);
            checkOutput({tag, " byte latency in window"},
                        ((bvCyc - lastFall) >= FILTER + 1 && (bvCyc - lastFall) <= FILTER + 5), 1);
        end
        if (expKv == 1) begin
            checkOutput({tag, " key_code"}, kvCode, expCode);
            checkOutput({tag, " key_ext"}, kvExt, expExt);
            checkOutput({tag, " key_break"}, kvBrk, expBrk);
            checkOutput({tag, " key after byte"}, kvCyc - bvCyc, 1);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {byte_out, byte_valid, key_code, key_ext, key_break,
                          key_valid, parity_err, frame_err}, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         badPar;
        bit         badStop;
        int         glitch;
        int         expBv;
        int         expKv;
        logic [7:0] expCode;
        bit         expExt;
        bit         expBrk;
        int         expPe;
        int         expFe;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit mExt, mBrk;
        logic [7:0] prefixes [6];

        Reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
        repeat (5) @(negedge clock);
        checkAllZero("reset outputs");
        Reset = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("no pulse after reset release", bvCount + kvCount + peCount + feCount, 0);

        //               data  bp bs gl  bv kv code  ext brk pe fe
        vecs.push_back('{8'h1C, 0, 0, -1, 1, 1, 8'h1C, 0, 0, 0, 0});
        vecs.push_back('{8'hF0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h1C, 0, 0, -1, 1, 1, 8'h1C, 0, 1, 0, 0});
        vecs.push_back('{8'hE0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'hF0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h75, 0, 0, -1, 1, 1, 8'h75, 1, 1, 0, 0});
        vecs.push_back('{8'h75, 0, 0, -1, 1, 1, 8'h75, 0, 0, 0, 0});
        vecs.push_back('{8'hE0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h1C, 1, 0, -1, 0, 0, 8'h00, 0, 0, 1, 0});
        vecs.push_back('{8'h32, 0, 0, -1, 1, 1, 8'h32, 0, 0, 0, 0});
        vecs.push_back('{8'hE0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h1C, 0, 1, -1, 0, 0, 8'h00, 0, 0, 0, 1});
        vecs.push_back('{8'h75, 0, 0, -1, 1, 1, 8'h75, 0, 0, 0, 0});
        vecs.push_back('{8'hF0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'hE0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h6B, 0, 0, -1, 1, 1, 8'h6B, 1, 1, 0, 0});
        vecs.push_back('{8'hE0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'hE0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h74, 0, 0, -1, 1, 1, 8'h74, 1, 0, 0, 0});
        vecs.push_back('{8'hF0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'hAA, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h1C, 0, 0, -1, 1, 1, 8'h1C, 0, 0, 0, 0});
        vecs.push_back('{8'hE0, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'hE1, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0, 0});
        vecs.push_back('{8'h14, 0, 0, -1, 1, 1, 8'h14, 1, 0, 0, 0});
        vecs.push_back('{8'h5A, 0, 0,  4, 1, 1, 8'h5A, 0, 0, 0, 0});

        foreach (vecs[i]) begin
            sendFrame(vecs[i].data, vecs[i].badPar, vecs[i].badStop, vecs[i].glitch);
            checkFrame($sformatf("vec%0d", i), vecs[i].expBv, vecs[i].data, vecs[i].expKv,
                       vecs[i].expCode, vecs[i].expExt, vecs[i].expBrk, vecs[i].expPe, vecs[i].expFe);
        end

        // Timeout after a partial frame. The pending E0 must be discarded.
        sendFrame(8'hE0, 0, 0, -1);
        snap();
        applyStimulus(mkFrame(8'h1C, 0, 0), 5, -1);
        repeat (TMO + 60) @(negedge clock);
        checkOutput("timeout frame_err", feCount - f0, 1);
        checkOutput("timeout no byte", bvCount - b0, 0);
        sendFrame(8'h32, 0, 0, -1);
        checkFrame("after timeout", 1, 8'h32, 1, 8'h32, 0, 0, 0, 0);

        // Reset asserted in the middle of a frame, after the fifth data bit.
        sendFrame(8'hE0, 0, 0, -1);
        snap();
        applyStimulus(mkFrame(8'h1C, 0, 0), 6, -1);
        @(negedge clock);
        Reset = 1'b1;
        repeat (5) @(negedge clock);
        checkAllZero("mid-frame reset outputs");
        Reset = 1'b0;
        repeat (SETTLE) @(negedge clock);
        checkOutput("mid-frame reset no pulses", (bvCount - b0) + (kvCount - k0) + (peCount - p0) + (feCount - f0), 0);
        sendFrame(8'h29, 0, 0, -1);
        checkFrame("after reset", 1, 8'h29, 1, 8'h29, 0, 0, 0, 0);

        // Randomized frames against the key-event model.
        prefixes = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00};
        mExt = 0; mBrk = 0;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            bit bp;
            int eBv, eKv, ePe;
            logic [7:0] eCode;
            bit eExt, eBrk;
            if ($urandom_range(0, 9) < 4) d = prefixes[$urandom_range(0, 5)];
            else                          d = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            eBv = 0; eKv = 0; ePe = 0; eCode = 8'h00; eExt = 0; eBrk = 0;
            if (bp) begin
                ePe = 1; mExt = 0; mBrk = 0;
            end else begin
                eBv = 1;
                if (d == 8'hE0) mExt = 1;
                else if (d == 8'hF0) mBrk = 1;
                else if (d inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
                    mExt = 0; mBrk = 0;
                end else if (d != 8'hE1) begin
                    eKv = 1; eCode = d; eExt = mExt; eBrk = mBrk;
                    mExt = 0; mBrk = 0;
                end
            end
            sendFrame(d, bp, 0, -1);
            checkFrame($sformatf("rand%0d(%02h)", n, d), eBv, d, eKv, eCode, eExt, eBrk, ePe, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
